// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: head + skid entry carrying payload and hazard fields.
// Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_elastic #(
  parameter int PAYLOAD_W = 96,
  parameter int REG_W     = 5,
  parameter int TNEW_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [REG_W-1:0]     in_wreg,
  input  logic [TNEW_W-1:0]    in_tnew,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [REG_W-1:0]     out_wreg,
  output logic [TNEW_W-1:0]    out_tnew
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  // Handshake: a transfer happens on a rising clk edge when valid && ready are
  // both high and flush is low; a transfer coinciding with flush is discarded.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   s_payload_q, s_payload_d;
  logic [REG_W-1:0]       s_wreg_q, s_wreg_d;
  logic [TNEW_W-1:0]      s_tnew_q, s_tnew_d;
  logic [PAYLOAD_W-1:0]   h_payload_d;
  logic [REG_W-1:0]       h_wreg_d;
  logic [TNEW_W-1:0]      h_tnew_d;
  logic                   out_valid_d, in_ready_d;
  logic                   accept, consume;
  logic [TNEW_W-1:0]      tnew_dec;

  assign accept   = in_valid && in_ready && !flush;
  assign consume  = out_valid && out_ready && !flush;
  // One stage boundary has elapsed by the time the entry is visible downstream.
  assign tnew_dec = (in_tnew == '0) ? '0 : in_tnew - 1'b1;

  always_comb begin
    state_d     = state_q;
    h_payload_d = out_payload;
    h_wreg_d    = out_wreg;
    h_tnew_d    = out_tnew;
    s_payload_d = s_payload_q;
    s_wreg_d    = s_wreg_q;
    s_tnew_d    = s_tnew_q;
    if (flush) begin
      state_d     = EMPTY;
      h_payload_d = '0;
      h_wreg_d    = '0;
      h_tnew_d    = '0;
      s_payload_d = '0;
      s_wreg_d    = '0;
      s_tnew_d    = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            h_payload_d = in_payload;
            h_wreg_d    = in_wreg;
            h_tnew_d    = tnew_dec;
          end
        end
        ONE: begin
          if (accept && consume) begin
            h_payload_d = in_payload;
            h_wreg_d    = in_wreg;
            h_tnew_d    = tnew_dec;
          end else if (accept) begin
            state_d     = TWO;
            s_payload_d = in_payload;
            s_wreg_d    = in_wreg;
            s_tnew_d    = tnew_dec;
          end else if (consume) begin
            // Clearing the head keeps out_wreg/out_tnew at 0 for bubbles.
            state_d     = EMPTY;
            h_payload_d = '0;
            h_wreg_d    = '0;
            h_tnew_d    = '0;
          end
        end
        TWO: begin
          if (consume) begin
            state_d     = ONE;
            h_payload_d = s_payload_q;
            h_wreg_d    = s_wreg_q;
            h_tnew_d    = s_tnew_q;
            s_payload_d = '0;
            s_wreg_d    = '0;
            s_tnew_d    = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      out_payload <= '0;
      out_wreg    <= '0;
      out_tnew    <= '0;
      s_payload_q <= '0;
      s_wreg_q    <= '0;
      s_tnew_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid   <= out_valid_d;
      in_ready    <= in_ready_d;
      out_payload <= h_payload_d;
      out_wreg    <= h_wreg_d;
      out_tnew    <= h_tnew_d;
      s_payload_q <= s_payload_d;
      s_wreg_q    <= s_wreg_d;
      s_tnew_q    <= s_tnew_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Counts cycles the head is held by downstream; flush does not clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed + random scoreboard bench for pipe_stage_elastic.
module tb_pipe_stage_elastic;
  localparam int PAYLOAD_W = 96;
  localparam int REG_W     = 5;
  localparam int TNEW_W    = 2;
  localparam int E_W       = PAYLOAD_W + REG_W + TNEW_W;
  localparam logic [PAYLOAD_W-1:0] DEAD_P = {3{32'hDEADBEEF}};

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [REG_W-1:0]     in_wreg;
  logic [TNEW_W-1:0]    in_tnew;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [REG_W-1:0]     out_wreg;
  logic [TNEW_W-1:0]    out_tnew;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]          stall_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int n_pop = 0;
  logic [E_W-1:0] exp_q[$];

  pipe_stage_elastic #(.PAYLOAD_W(PAYLOAD_W), .REG_W(REG_W), .TNEW_W(TNEW_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_wreg(in_wreg), .in_tnew(in_tnew),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_wreg(out_wreg), .out_tnew(out_tnew)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TNEW_W-1:0] tnew_model(input logic [TNEW_W-1:0] t);
    return (t == 0) ? '0 : TNEW_W'(t - 1);
  endfunction

  // driver: present an entry on the input side
  task automatic set_in(input logic [PAYLOAD_W-1:0] p, input logic [REG_W-1:0] w,
                        input logic [TNEW_W-1:0] t);
    in_valid   = 1'b1;
    in_payload = p;
    in_wreg    = w;
    in_tnew    = t;
  endtask

  // Evaluate this edge's handshakes against the scoreboard, then advance one cycle.
  task automatic tick();
    logic [E_W-1:0] e;
    if (out_valid === 1'b0) begin
      check("bubble_wreg", out_wreg, 0);
      check("bubble_tnew", out_tnew, 0);
    end
    if (flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL underflow: observed output with empty expected queue");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_entry", {out_payload, out_wreg, out_tnew}, e);
          n_pop++;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_payload, in_wreg, tnew_model(in_tnew)});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && out_valid; i++) tick();
    check({tag, "_drained"}, out_valid, 0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int start_pop;
    logic c_acc;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_payload = '0; in_wreg = '0; in_tnew = '0;
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_payload", out_payload, 0);
    check("rst_wreg", out_wreg, 0);
    check("rst_tnew", out_tnew, 0);
    reset = 1'b1;
    tick();

    // stream at full rate
    out_ready = 1'b1;
    set_in(96'hA1, 5'd5, 2'd2); tick();
    check("lat_out_valid", out_valid, 1);
    check("stream_tnew0", out_tnew, 1);
    check("stream_wreg0", out_wreg, 5);
    set_in(96'hA2, 5'd6, 2'd1); tick();
    check("stream_tnew1", out_tnew, 0);
    check("stream_wreg1", out_wreg, 6);
    set_in(96'hA3, 5'd7, 2'd0); tick();
    check("stream_tnew2", out_tnew, 0);
    check("stream_wreg2", out_wreg, 7);
    check("stream_nogap", out_valid, 1);
    drain("stream");

    // back-pressure
    out_ready = 1'b0;
    start_pop = n_pop;
    set_in(96'hB1, 5'd1, 2'd3); tick();
    check("bp_ready_one", in_ready, 1);
    set_in(96'hB2, 5'd2, 2'd2); tick();
    check("bp_ready_full", in_ready, 0);
    check("bp_head", out_wreg, 1);
    set_in(96'hB3, 5'd3, 2'd1); tick(); tick();
    check("bp_held_ready", in_ready, 0);
    check("bp_held_q", exp_q.size(), 2);
    out_ready = 1'b1;
    c_acc = 1'b0;
    for (int i = 0; i < 10 && !c_acc; i++) begin
      c_acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    check("bp_c_accepted", c_acc, 1);
    drain("bp");
    check("bp_pops", n_pop - start_pop, 3);

    // flush with simultaneous accept in ONE
    out_ready = 1'b0;
    set_in(96'hC1, 5'd9, 2'd1); tick();
    set_in(DEAD_P, 5'd10, 2'd2);
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_out_valid", out_valid, 0);
    check("fl1_wreg", out_wreg, 0);
    check("fl1_payload", out_payload, 0);

    // bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bubble_valid", out_valid, 0);
      check("bubble_nodead", out_payload == DEAD_P, 0);
    end

    // flush in TWO
    out_ready = 1'b0;
    set_in(96'hD1, 5'd11, 2'd1); tick();
    set_in(96'hD2, 5'd12, 2'd2); tick();
    in_valid = 1'b0;
    check("fl2_pre_ready", in_ready, 0);
    flush = 1'b1; tick();
    flush = 1'b0;
    check("fl2_out_valid", out_valid, 0);
    check("fl2_in_ready", in_ready, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_payload = {$urandom, $urandom, $urandom};
      in_wreg    = REG_W'($urandom_range(0, 31));
      in_tnew    = TNEW_W'($urandom_range(0, 3));
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;
    drain("rand");

    // reset mid-stream, checked before the next edge
    out_ready = 1'b0;
    set_in(96'hE1, 5'd13, 2'd1); tick();
    set_in(96'hE2, 5'd14, 2'd1); tick();
    in_valid = 1'b0;
    check("rst_mid_full", in_ready, 0);
    reset = 1'b0;
    #1;
    check("rstm_out_valid", out_valid, 0);
    check("rstm_in_ready", in_ready, 1);
    check("rstm_payload", out_payload, 0);
    check("rstm_wreg", out_wreg, 0);
    check("rstm_tnew", out_tnew, 0);
    exp_q.delete();
    #2 reset = 1'b1;
    @(negedge clk);
    check("rstm_after_valid", out_valid, 0);
    check("rstm_after_ready", in_ready, 1);

`ifdef PIPE_STAGE_PERF_EN
    check("perf_rst", stall_cnt, 0);
    out_ready = 1'b0;
    set_in(96'hF1, 5'd15, 2'd0); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("perf_ten", stall_cnt, 10);
    out_ready = 1'b1; flush = 1'b1; tick();
    flush = 1'b0;
    check("perf_flush_keep", stall_cnt, 10);
    out_ready = 1'b0;
    set_in(96'hF2, 5'd16, 2'd0); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 65600; i++) @(negedge clk);
    check("perf_sat", stall_cnt, 16'hFFFF);
    drain("perf");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
